// File: rtl/host_fifo_pkg.sv
// Shared definitions for the host-side FIFO arbiters: header count field
// widths, payload-length mapping and the tx arbiter state encoding.
package host_fifo_pkg;

   localparam int unsigned FIFO_CNT_WIDTH     = 3;
   localparam int unsigned FIFO_PAYLOAD_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAYLOAD
   } arb_tx_state_t;

   // Count code maps directly onto the number of payload bytes following the header.
   function automatic logic [FIFO_PAYLOAD_WIDTH-1:0] fifo_payload(input logic [FIFO_CNT_WIDTH-1:0] cnt);
      return cnt;
   endfunction

   function automatic int unsigned lowest_set_bit(input logic [31:0] mask);
      int unsigned pos;
      pos = 0;
      for (int unsigned i = 32; i > 0; i--) begin
         if (mask[i-1]) pos = i - 1;
      end
      return pos;
   endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with registered read data (one-cycle read latency) and
// synchronous flush on rst. Writes when full and reads when empty are ignored.
module fifo #(
   parameter int unsigned DEPTH_WIDTH = 3,
   parameter int unsigned DATA_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty
);

   typedef logic [DEPTH_WIDTH:0] ptr_t;

   logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_WIDTH];
   ptr_t                  wr_ptr_q, wr_ptr_d;
   ptr_t                  rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  wr_ok, rd_ok;

   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[DEPTH_WIDTH] != rd_ptr_q[DEPTH_WIDTH]) &&
                  (wr_ptr_q[DEPTH_WIDTH-1:0] == rd_ptr_q[DEPTH_WIDTH-1:0]);
      wr_ok     = wr_en && !full;
      rd_ok     = rd_en && !empty;
      wr_ptr_d  = wr_ok ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d  = rd_ok ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      rd_data_d = rd_ok ? mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]] : rd_data_q;
      rd_data   = rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

endmodule

// File: rtl/fifo_arb_tx.sv
// Two-client transmit arbiter: per-client FIFOs drained round-robin into the
// host FIFO one whole packet at a time, with c1/c2 header tagging.
module fifo_arb_tx
   import host_fifo_pkg::*;
#(
   parameter int unsigned       DWIDTH  = 8,
   parameter int unsigned       AWIDTH  = 3,
   parameter logic [DWIDTH-1:0] SELMASK = 8'h80,
   parameter logic [DWIDTH-1:0] CNTMASK = 8'h70,
   parameter bit                TAG_EN  = 1'b1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              c1_wren,
   output logic              c1_wrfull,
   input  logic [DWIDTH-1:0] c1_wrdata,
   input  logic              c2_wren,
   output logic              c2_wrfull,
   input  logic [DWIDTH-1:0] c2_wrdata,
   output logic              fifo_wren,
   input  logic              fifo_wrfull,
   output logic [DWIDTH-1:0] fifo_wrdata,
   output logic              busy
);

   localparam int unsigned CNT_SHIFT = lowest_set_bit(32'(CNTMASK));

   arb_tx_state_t                 state_q, state_d;
   logic                          sel_q, sel_d;   // 0 = c1, 1 = c2
   logic                          rr_q, rr_d;
   logic                          pending_q, pending_d;
   logic [FIFO_PAYLOAD_WIDTH-1:0] remaining_q, remaining_d;

   logic                          c1_empty, c2_empty, c1_rd_en, c2_rd_en, rd_issue;
   logic [DWIDTH-1:0]             c1_rd_data, c2_rd_data, rd_byte;
   logic [FIFO_CNT_WIDTH-1:0]     hdr_cnt;

   fifo #(.DEPTH_WIDTH(AWIDTH), .DATA_WIDTH(DWIDTH)) u_c1_fifo (
      .clk(CLK), .rst(RESET), .wr_en(c1_wren), .wr_data(c1_wrdata), .full(c1_wrfull),
      .rd_en(c1_rd_en), .rd_data(c1_rd_data), .empty(c1_empty)
   );

   fifo #(.DEPTH_WIDTH(AWIDTH), .DATA_WIDTH(DWIDTH)) u_c2_fifo (
      .clk(CLK), .rst(RESET), .wr_en(c2_wren), .wr_data(c2_wrdata), .full(c2_wrfull),
      .rd_en(c2_rd_en), .rd_data(c2_rd_data), .empty(c2_empty)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_d        = rr_q;
      remaining_d = remaining_q;
      rd_byte     = sel_q ? c2_rd_data : c1_rd_data;
      hdr_cnt     = FIFO_CNT_WIDTH'((rd_byte & CNTMASK) >> CNT_SHIFT);
      // pending blocks back-to-back reads, so each issued byte saw fifo_wrfull=0
      rd_issue    = (state_q != IDLE) && !(sel_q ? c2_empty : c1_empty) &&
                    !fifo_wrfull && !pending_q;
      c1_rd_en    = rd_issue && !sel_q;
      c2_rd_en    = rd_issue && sel_q;
      pending_d   = rd_issue;
      busy        = (state_q != IDLE);
      fifo_wren   = pending_q;
      fifo_wrdata = '0;
      if (pending_q) begin
         fifo_wrdata = rd_byte;
         if (TAG_EN && state_q == HDR)
            fifo_wrdata = sel_q ? (rd_byte & ~SELMASK) : (rd_byte | SELMASK);
      end

      case (state_q)
         IDLE: begin
            if (!c1_empty || !c2_empty) begin
               sel_d   = (!c1_empty && !c2_empty) ? rr_q : c1_empty;
               state_d = HDR;
            end
         end
         HDR: begin
            if (pending_q) begin
               remaining_d = fifo_payload(hdr_cnt);
               if (remaining_d == '0) begin
                  state_d = IDLE;
                  rr_d    = !rr_q;
               end else begin
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (pending_q) begin
               remaining_d = remaining_q - FIFO_PAYLOAD_WIDTH'(1);
               if (remaining_q == FIFO_PAYLOAD_WIDTH'(1)) begin
                  state_d = IDLE;
                  rr_d    = !rr_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         rr_q        <= 1'b0;
         pending_q   <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         rr_q        <= rr_d;
         pending_q   <= pending_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: tb/tb_fifo_arb_tx.sv
// Scoreboard bench for fifo_arb_tx: a packet-level model predicts the host byte
// order, a separate monitor compares every host write against it.
module tb_fifo_arb_tx;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       c1_wren = 1'b0, c2_wren = 1'b0, fifo_wrfull = 1'b0;
   logic [7:0] c1_wrdata = '0, c2_wrdata = '0;
   logic       c1_wrfull, c2_wrfull, fifo_wren, busy;
   logic [7:0] fifo_wrdata;

   int         tests = 0;
   int         fails = 0;
   int         n_out = 0;
   logic [7:0] exp_q[$];
   logic [7:0] ld1[$], ld2[$], m1[$], m2[$];
   bit         rr_m = 1'b0;
   bit         rnd_full = 1'b0;

   fifo_arb_tx #(
      .DWIDTH(8), .AWIDTH(3), .SELMASK(8'h80), .CNTMASK(8'h70), .TAG_EN(1'b1)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .c1_wren(c1_wren), .c1_wrfull(c1_wrfull), .c1_wrdata(c1_wrdata),
      .c2_wren(c2_wren), .c2_wrfull(c2_wrfull), .c2_wrdata(c2_wrdata),
      .fifo_wren(fifo_wren), .fifo_wrfull(fifo_wrfull), .fifo_wrdata(fifo_wrdata),
      .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every host write must match the next predicted byte and must not
   // follow a cycle in which the host FIFO reported full.
   initial begin
      logic prev_full;
      logic [7:0] e;
      prev_full = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RESET && fifo_wren) begin
            n_out++;
            check("write_after_full", 32'(prev_full), 0);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got 0x%0h, expected no write", fifo_wrdata);
            end else begin
               e = exp_q.pop_front();
               check("host_byte", 32'(fifo_wrdata), 32'(e));
            end
         end
         prev_full = fifo_wrfull;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rnd_full) fifo_wrfull = ($urandom_range(0, 3) == 0);
   endtask

   // Packet-level reference: whole packets, round-robin when both clients have one.
   task automatic run_model();
      bit         pick;
      logic [7:0] h;
      int         n;
      while (m1.size() > 0 || m2.size() > 0) begin
         pick = (m1.size() > 0 && m2.size() > 0) ? rr_m : (m1.size() == 0);
         h = pick ? m2.pop_front() : m1.pop_front();
         exp_q.push_back(pick ? (h & 8'h7F) : (h | 8'h80));
         n = int'(h[6:4]);
         repeat (n) exp_q.push_back(pick ? m2.pop_front() : m1.pop_front());
         rr_m = !rr_m;
      end
   endtask

   // Loads both clients in lockstep with the host held full so the whole set is
   // queued before the first arbitration outcome is committed.
   task automatic drive_load();
      int n;
      rnd_full    = 1'b0;
      fifo_wrfull = 1'b1;
      n = (ld1.size() > ld2.size()) ? ld1.size() : ld2.size();
      for (int i = 0; i < n; i++) begin
         c1_wren   = (i < ld1.size());
         c1_wrdata = c1_wren ? ld1[i] : 8'h00;
         c2_wren   = (i < ld2.size());
         c2_wrdata = c2_wren ? ld2[i] : 8'h00;
         tick();
      end
      c1_wren = 1'b0;
      c2_wren = 1'b0;
      tick();
      fifo_wrfull = 1'b0;
   endtask

   task automatic load_round();
      m1 = ld1;
      m2 = ld2;
      run_model();
      drive_load();
   endtask

   task automatic drain(input bit rnd);
      int cyc;
      cyc = 0;
      rnd_full = rnd;
      while ((exp_q.size() > 0 || busy) && cyc < 3000) begin
         tick();
         cyc++;
      end
      rnd_full    = 1'b0;
      fifo_wrfull = 1'b0;
      check("drain_in_time", 32'(cyc < 3000), 1);
      if (cyc >= 3000) exp_q.delete();
      repeat (3) tick();
   endtask

   task automatic wait_out(input int target);
      int cyc;
      cyc = 0;
      while (n_out < target && cyc < 200) begin
         tick();
         cyc++;
      end
      check("reach_output_count", 32'(n_out), 32'(target));
   endtask

   initial begin
      int base;
      int budget;
      int cnt;
      logic [7:0] h;

      RESET = 1'b1;
      repeat (3) tick();
      check("rst_fifo_wren", 32'(fifo_wren), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_c1_wrfull", 32'(c1_wrfull), 0);
      check("rst_c2_wrfull", 32'(c2_wrfull), 0);
      check("rst_fifo_wrdata", 32'(fifo_wrdata), 0);
      RESET = 1'b0;
      tick();

      ld1 = '{8'h00};              ld2 = {};
      load_round(); drain(1'b0);
      check("busy_after_single", 32'(busy), 0);

      ld1 = {};                    ld2 = '{8'hA0, 8'h80, 8'h11};
      load_round(); drain(1'b0);

      ld1 = '{8'h20, 8'hAA, 8'hBB}; ld2 = '{8'h10, 8'hCC};
      load_round(); drain(1'b0);
      ld1 = '{8'h00};              ld2 = '{8'h00};
      load_round(); drain(1'b0);

      // host full held across the second payload byte
      base = n_out;
      ld1 = '{8'h20, 8'hAA, 8'hBB}; ld2 = {};
      load_round();
      wait_out(base + 2);
      fifo_wrfull = 1'b1;
      repeat (10) tick();
      check("hold_no_write", 32'(n_out), 32'(base + 2));
      fifo_wrfull = 1'b0;
      drain(1'b0);
      check("hold_one_more", 32'(n_out), 32'(base + 3));

      ld1 = {};                    ld2 = '{8'h10, 8'h55};
      load_round(); drain(1'b0);

      // starvation: c2 must wait for c1's packet to complete
      base = n_out;
      m1 = '{8'h20, 8'hAA, 8'hBB}; m2 = '{8'h00};
      run_model();
      ld1 = '{8'h20, 8'hAA};       ld2 = '{8'h00};
      drive_load();
      wait_out(base + 2);
      repeat (20) tick();
      check("starve_no_c2", 32'(n_out), 32'(base + 2));
      check("starve_busy", 32'(busy), 1);
      c1_wren = 1'b1; c1_wrdata = 8'hBB;
      tick();
      c1_wren = 1'b0;
      drain(1'b0);
      check("starve_total", 32'(n_out), 32'(base + 4));

      // same stall, aborted by reset
      base = n_out;
      m1 = '{8'h20, 8'hAA, 8'hBB}; m2 = '{8'h00};
      run_model();
      ld1 = '{8'h20, 8'hAA};       ld2 = '{8'h00};
      drive_load();
      wait_out(base + 2);
      repeat (5) tick();
      RESET = 1'b1;
      tick();
      check("abort_busy", 32'(busy), 0);
      check("abort_fifo_wren", 32'(fifo_wren), 0);
      check("abort_c1_wrfull", 32'(c1_wrfull), 0);
      check("abort_c2_wrfull", 32'(c2_wrfull), 0);
      check("abort_lost_bytes", 32'(exp_q.size()), 2);
      exp_q.delete();
      rr_m  = 1'b0;
      RESET = 1'b0;
      repeat (20) tick();
      check("abort_flushed", 32'(n_out), 32'(base + 2));
      check("abort_idle", 32'(busy), 0);

      for (int r = 0; r < 40; r++) begin
         ld1 = {};
         ld2 = {};
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 3) != 0) begin
               budget = 8;
               forever begin
                  cnt = $urandom_range(0, 2);
                  if (cnt + 1 > budget) break;
                  h = 8'(($urandom & 32'h8F) | 32'(cnt << 4));
                  if (c == 0) ld1.push_back(h); else ld2.push_back(h);
                  repeat (cnt) begin
                     h = 8'($urandom);
                     if (c == 0) ld1.push_back(h); else ld2.push_back(h);
                  end
                  budget -= cnt + 1;
                  if ($urandom_range(0, 2) == 0) break;
               end
            end
         end
         load_round();
         drain(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish, expected finish before 900000");
      $fatal(1);
   end

endmodule

// File: doc/fifo_arb_tx.md
Name: fifo_arb_tx

Overview:
- Transmit-side counterpart of the rx arbiter: merges packet streams from two clients into the single host output FIFO.
- Each client writes into its own internal FIFO. A round-robin arbiter forwards whole packets (header plus payload) atomically to the host FIFO.
- Headers are tagged with the SELMASK bit so the far-end rx arbiter can route them back by client.

Parameters:
- SELMASK, 8'h80: header bit set on c1 headers and cleared on c2 headers (when TAG_EN=1).
- CNTMASK, 8'h70: contiguous 3-bit count field in the header.
- DWIDTH, 8: data width.
- AWIDTH, 3: address width of each internal FIFO (depth 2**AWIDTH).
- TAG_EN, 1: 1 = apply SELMASK tagging; 0 = pass headers unmodified.

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- c1_wren  in  1  client 1 write strobe.
- c1_wrfull  out  1  client 1 internal FIFO full.
- c1_wrdata  in  DWIDTH  client 1 write data.
- c2_wren  in  1  client 2 write strobe.
- c2_wrfull  out  1  client 2 internal FIFO full.
- c2_wrdata  in  DWIDTH  client 2 write data.
- fifo_wren  out  1  write strobe to host output FIFO.
- fifo_wrfull  in  1  host output FIFO full.
- fifo_wrdata  out  DWIDTH  data to host output FIFO.
- busy  out  1  high while a packet is in flight (state != IDLE).

Behaviour:
- Reset values (RESET high at a clock edge): fifo_wren=0, fifo_wrdata=0, busy=0, state=IDLE, rr priority=c1, remaining=0, internal FIFOs flushed (wrfull=0).
- Client writes while c*_wrfull=1 are ignored by the internal FIFO; clients must not rely on them.
- Internal FIFO read latency is 1 cycle: data is valid the cycle after rd_en. A "pending" flag marks that cycle.
- Read issue rule: assert rd_en to the selected FIFO only when all of the following hold:
  - the FIFO is not empty;
  - fifo_wrfull=0;
  - pending=0.
- This gives at most one byte per 2 cycles and guarantees no write is issued into a full host FIFO.
- fifo_wren=1 exactly in the pending cycle; fifo_wrdata equals the read byte (tagged if it is a header). Combinational from registered FIFO output.
- Count field: cnt = (hdr & CNTMASK) >> (lowest set bit of CNTMASK). Payload length = fifo_payload(cnt), width FIFO_PAYLOAD_WIDTH.
- States:
  - IDLE: choose a client whose FIFO is non-empty.
    - Both non-empty: take the rr-priority client.
    - One non-empty: take it.
    - Go to HDR. No read is issued in IDLE.
  - HDR: issue one read (per the rule above).
    - In the pending cycle, write the header with tagging:
      - TAG_EN=1: c1 -> hdr | SELMASK; c2 -> hdr & ~SELMASK.
    - Load remaining = fifo_payload(cnt), computed from the untagged header.
    - remaining==0 -> IDLE. Otherwise -> PAYLOAD.
  - PAYLOAD: issue reads from the selected client only. Each write decrements remaining.
    - The write that takes remaining to 0 returns to IDLE on the next edge.
    - Payload bytes are never tagged, even if they contain SELMASK bits.
- rr priority toggles to the other client each time a packet completes (on entry to IDLE). This holds even if the other client was idle.
- Packet atomicity:
  - While in HDR/PAYLOAD, the other client is never serviced, even if the selected FIFO runs empty. The arbiter waits indefinitely.
  - Client writes continue to be accepted into both FIFOs throughout.
- fifo_wrfull asserting: no new reads are issued. An already pending byte is still written, because the rule guaranteed space at issue.
- RESET mid-packet: abort immediately. The partial packet is lost and both internal FIFOs are flushed. It is the host's responsibility to resynchronise.
- Simultaneous events:
  - A client write and an arbiter read on the same FIFO in the same cycle are both honoured.
  - A client write to an empty FIFO is visible to IDLE selection on the following cycle.

Decomposition:
- host_fifo_pkg (shared, existing) supplies:
  - FIFO_CNT_WIDTH (3) and FIFO_PAYLOAD_WIDTH;
  - fifo_payload(cnt), for which codes 0,1,2 map to 0,1,2 payload bytes;
  - an arb_tx_state_t enum (IDLE, HDR, PAYLOAD).
- Two instances of the common fifo module (DEPTH_WIDTH=AWIDTH, DATA_WIDTH=DWIDTH, rst=RESET).
- Arbiter FSM inline; no further sub-module.

Test Plan:
- Reset: hold RESET 3 cycles -> fifo_wren=0, busy=0, c1_wrfull=c2_wrfull=0.
- c1 writes header 0x00 -> single fifo write 0x80 two cycles after selection; busy returns to 0.
- c2 writes 0xA0, 0x80, 0x11 (cnt=2) -> host sees 0x20, 0x80, 0x11 (payload 0x80 not modified).
- Both FIFOs preloaded: c1 0x20, 0xAA, 0xBB; c2 0x10, 0xCC -> host order 0xA0, 0xAA, 0xBB, 0x10, 0xCC. A next simultaneous pair is served c1 first again, because rr toggled to c2 then back to c1.
- fifo_wrfull held high 10 cycles after first payload byte of c1 0x20, 0xAA, 0xBB -> no fifo_wren during hold, then 0xBB once. No loss or duplicate.
- Starvation: c1 writes 0x20, 0xAA only; c2 writes 0x00 -> c2 not output until c1 writes 0xBB. Order: 0xA0, 0xAA, 0xBB, 0x00. RESET asserted mid-wait -> busy=0 and both FIFOs empty next cycle.
